// File: rtl/conv_pkg.sv
// Shared types, constants and the result-to-pixel saturation
// used by the convolution output streamer.
package conv_pkg;

    localparam int CONV_IMG_W = 128;
    localparam int CONV_IMG_H = 128;
    localparam int CONV_RES_W = 16;
    localparam int PIX_W      = 8;

    localparam logic SAT_CLAMP = 1'b0;
    localparam logic SAT_ABS   = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // One extra bit keeps |most-negative| representable before clamping.
    function automatic logic [PIX_W-1:0] sat8(
        input logic signed [31:0] v,
        input logic                mode
    );
        logic signed [32:0] a;
        a = {v[31], v};
        if (mode == SAT_ABS && v[31]) begin
            a = -a;
        end
        if (a[32]) begin
            sat8 = '0;
        end else if (a > 33'sd255) begin
            sat8 = '1;
        end else begin
            sat8 = a[PIX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/conv_skid_fifo.sv
// Two-entry FIFO whose head is presented combinationally;
// simultaneous push and pop are accepted even when full.
module conv_skid_fifo
    import conv_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wp_q;
    logic         rp_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign count   = cnt_q;
    assign dout    = mem_q[rp_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wp_q] <= din;
                wp_q        <= ~wp_q;
            end
            if (do_pop) begin
                rp_q <= ~rp_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/conv_out_streamer.sv
// Reads convolution results after done, saturates them to pixels
// and streams the frame in raster order with sof/eol/eof tags.
module conv_out_streamer
    import conv_pkg::*;
#(
    parameter int IMG_W = CONV_IMG_W,
    parameter int IMG_H = CONV_IMG_H,
    parameter int RES_W = CONV_RES_W,
    parameter int AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sat_mode,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [RES_W-1:0] rd_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof,
    output logic             m_eol,
    output logic             m_eof,
    output logic             busy,
    output logic             done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int FW = PIX_W + 3;

    state_t        state_q;
    state_t        state_d;
    logic [AW-1:0] addr_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          mode_q;
    logic          inflight_q;
    logic [2:0]    tag_q;
    logic          done_q;

    logic          start_acc;
    logic          frame_end;
    logic          x_last;
    logic          y_last;
    logic          can_issue;
    logic [2:0]    pend;
    logic          pop;
    logic [FW-1:0] push_word;
    logic [FW-1:0] head;
    logic          f_full;
    logic          f_empty;
    logic [1:0]    f_count;

    assign x_last = (x_q == XW'(IMG_W - 1));
    assign y_last = (y_q == YW'(IMG_H - 1));
    assign pop    = m_valid && m_ready;

    // Occupancy after this cycle's pop, plus the read still in flight.
    assign pend      = {1'b0, f_count} + {2'b0, inflight_q} - {2'b0, pop};
    assign can_issue = !f_full && (pend < 3'd2);

    always_comb begin
        state_d   = state_q;
        rd_en     = 1'b0;
        start_acc = 1'b0;
        frame_end = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !done_q) begin
                    state_d   = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                rd_en = can_issue;
                if (can_issue && x_last && y_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && m_eof) begin
                    state_d   = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            mode_q     <= 1'b0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= frame_end;
            inflight_q <= rd_en;
            tag_q      <= {x_last && y_last && (x_q == '0) ? 1'b0 : (x_q == '0 && y_q == '0),
                           x_last,
                           x_last && y_last};
            if (start_acc) begin
                addr_q <= '0;
                x_q    <= '0;
                y_q    <= '0;
                mode_q <= sat_mode;
            end else if (rd_en) begin
                addr_q <= addr_q + 1'b1;
                if (x_last) begin
                    x_q <= '0;
                    y_q <= y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
        end
    end

    assign push_word = {tag_q, sat8(32'(signed'(rd_data)), mode_q)};

    conv_skid_fifo #(
        .W(FW)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight_q),
        .din  (push_word),
        .pop  (pop),
        .dout (head),
        .full (f_full),
        .empty(f_empty),
        .count(f_count)
    );

    assign rd_addr = addr_q;
    assign m_valid = !f_empty;
    assign m_data  = m_valid ? head[PIX_W-1:0] : '0;
    assign m_sof   = m_valid && head[PIX_W+2];
    assign m_eol   = m_valid && head[PIX_W+1];
    assign m_eof   = m_valid && head[PIX_W];
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_conv_out_streamer.sv
// Scoreboard bench for conv_out_streamer on a 4x2 frame with
// backpressure, stray starts and a mid-frame reset.
module tb_conv_out_streamer;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          sat_mode = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [7:0]    m_data;
    logic          m_sof;
    logic          m_eol;
    logic          m_eof;
    logic          busy;
    logic          done;

    logic signed [15:0] mem [N];
    int vals0 [N] = '{-5, 300, 32767, 127, 0, 255, 256, -32768};
    int vals1 [N] = '{-5, -200, -32768, 255, 256, 0, 1, -1};

    int total = 0;
    int bad   = 0;
    logic [10:0] q [$];

    int   occ = 0;
    bit   arr = 1'b0;
    bit   pop_n = 1'b0;
    bit   rd_n = 1'b0;
    bit   stall = 1'b0;
    logic [11:0] held = '0;
    int   exp_addr = 0;
    int   dk;

    always #5 clk = ~clk;

    conv_out_streamer #(
        .IMG_W(W),
        .IMG_H(H)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sat_mode(sat_mode),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sof   (m_sof),
        .m_eol   (m_eol),
        .m_eof   (m_eof),
        .busy    (busy),
        .done    (done)
    );

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sat_ref(input int v, input bit m);
        int a;
        a = (m && v < 0) ? -v : v;
        if (a < 0) return 8'd0;
        if (a > 255) return 8'd255;
        return a[7:0];
    endfunction

    task automatic fill(input bit m);
        q.delete();
        exp_addr = 0;
        for (int i = 0; i < N; i++) begin
            q.push_back({i == 0, (i % W) == W - 1, i == N - 1,
                         sat_ref(int'(mem[i]), m)});
        end
    endtask

    always @(negedge clk) begin
        pop_n = m_valid && m_ready;
        rd_n  = rd_en;
        if (!rst) begin
            chk("m_valid", m_valid, occ != 0);
            chk("outstanding", (occ + arr) <= 2, 1);
            if (arr && occ == 2 && !pop_n) chk("push_full", 1, 0);
            if (stall) chk("hold", {m_valid, m_sof, m_eol, m_eof, m_data}, held);
            if (rd_en) begin
                chk("rd_addr", rd_addr, exp_addr);
                exp_addr++;
            end
            if (pop_n) begin
                if (q.size() == 0) chk("extra_beat", 1, 0);
                else chk("beat", {m_sof, m_eol, m_eof, m_data}, q.pop_front());
            end
            stall = m_valid && !m_ready;
            held  = {1'b1, m_sof, m_eol, m_eof, m_data};
        end else begin
            stall = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            occ <= 0;
            arr <= 1'b0;
        end else begin
            occ <= occ + int'(arr) - int'(pop_n);
            arr <= rd_n;
        end
    end

    // style 0: full rate, 1: backpressure, 2: stray start, 3: start in done cycle
    task automatic run_frame(input bit m, input int style, output int dn);
        int j;
        fill(m);
        start    = 1'b1;
        sat_mode = m;
        m_ready  = 1'b1;
        dn       = -1;
        for (int k = 0; k < 300 && dn < 0; k++) begin
            @(negedge clk);
            if (style == 0) chk("busy", busy, k >= 1 && k <= N + 2);
            if (done) dn = k;
            @(posedge clk);
            #1;
            j        = k + 1;
            start    = (style == 2 && j == 5) || (style == 3 && j == N + 3);
            sat_mode = ~m;
            if (style == 1)
                m_ready = (j >= 5 && j < 10) ? 1'b0 : (j >= 10 ? (j % 2 == 0) : 1'b1);
        end
        if (dn < 0) chk("timeout", 0, 1);
        chk("q_left", q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", {rd_en, rd_addr, m_valid, m_data, m_sof, m_eol,
                        m_eof, busy, done}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < N; i++) mem[i] = 16'(i);
        run_frame(1'b0, 0, dk);
        chk("done_lat", dk, N + 3);
        run_frame(1'b0, 3, dk);
        chk("done_lat2", dk, N + 3);
        @(negedge clk);
        chk("start_in_done", busy, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) mem[i] = 16'(vals0[i]);
        run_frame(1'b0, 1, dk);
        for (int i = 0; i < N; i++) mem[i] = 16'(vals1[i]);
        run_frame(1'b1, 2, dk);

        for (int i = 0; i < N; i++) mem[i] = 16'(i + 10);
        fill(1'b0);
        start    = 1'b1;
        sat_mode = 1'b0;
        m_ready  = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        rst = 1'b1;
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid", {rd_en, rd_addr, m_valid, m_data, m_sof, m_eol,
                        m_eof, busy, done}, 0);
        @(negedge clk);
        chk("rst_discard", m_valid, 0);
        @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) mem[i] = 16'(i * 3);
        run_frame(1'b0, 0, dk);
        chk("done_lat3", dk, N + 3);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
